// File: rtl/arcfour_search_core_if.sv
// RAM-side bus of the RC4 key-search core: S RAM, ciphertext ROM and plaintext RAM.
// master = search core, slave = memory side.
interface arcfour_search_core_if #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int MESSAGE_LOG_LENGTH = 5
);
    logic [RAM_LENGTH-1:0]         sAddr;
    logic [RAM_WIDTH-1:0]          sIn;
    logic                          sWren;
    logic [RAM_WIDTH-1:0]          sOut;
    logic [MESSAGE_LOG_LENGTH-1:0] kAddr;
    logic [7:0]                    kOut;
    logic [MESSAGE_LOG_LENGTH-1:0] aAddr;
    logic [7:0]                    aIn;
    logic                          aWren;

    modport master (
        output sAddr, sIn, sWren, kAddr, aAddr, aIn, aWren,
        input  sOut, kOut
    );

    modport slave (
        input  sAddr, sIn, sWren, kAddr, aAddr, aIn, aWren,
        output sOut, kOut
    );
endinterface

// File: rtl/arcfour_search_core.sv
// RC4 brute-force key-search core. Walks keys key_lower+CORE_ID .. key_upper with
// stride NUM_CORES; for each key it initialises and schedules S in external RAM,
// then decrypts the ciphertext ROM into the plaintext RAM and stops on the first
// key whose plaintext is entirely printable (a-z or space).
// Optional feature: define ARCFOUR_EARLY_ABORT_EN to drop a key at its first
// non-printable byte instead of decrypting the whole message.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// INIT     | S[i] = i, one write per cycle
// KSA_RI   | address S[i]
// KSA_WI   | si = S[i], j += si + key byte, address S[j]
// KSA_RJ   | wait for S[j]
// KSA_WJ   | sj = S[j]
// KSA_SWI  | write S[i] = sj
// KSA_SWJ  | write S[j] = si, advance i
// P_INC    | i += 1, address S[i]
// P_RI     | wait for S[i]
// P_WI     | si = S[i], j += si, address S[j]
// P_RJ     | wait for S[j]
// P_WJ     | sj = S[j]
// P_SWI    | write S[i] = sj
// P_SWJ    | write S[j] = si, address S[si+sj] and ciphertext byte k
// P_RF     | wait for keystream and ciphertext bytes
// P_WF     | plaintext write, printable test, next byte / key / done
// NEXT_KEY | count rejected key, step key or finish
// DONE     | result held until start or reset
module arcfour_search_core #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter int NUM_CORES          = 1,
    parameter int CORE_ID            = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             halt,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_lower,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_upper,
    output logic                             busy,
    output logic                             succeeded,
    output logic                             terminated,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  outKey,
    output logic [31:0]                      keys_tried,
    arcfour_search_core_if.master            mem
);
    localparam int KW  = KEY_LENGTH * RAM_WIDTH;
    localparam int KW1 = KW + 1;
    localparam int KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [KIW-1:0] KEY_IDX_MAX = KIW'(KEY_LENGTH - 1);
    localparam logic [RAM_LENGTH-1:0] IDX_MAX = '1;
    localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_BYTE = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

    if (RAM_WIDTH != RAM_LENGTH) begin : gParamCheck
        $error("arcfour_search_core: RAM_WIDTH must equal RAM_LENGTH");
    end

    typedef enum logic [4:0] {
        IDLE, INIT,
        KSA_RI, KSA_WI, KSA_RJ, KSA_WJ, KSA_SWI, KSA_SWJ,
        P_INC, P_RI, P_WI, P_RJ, P_WJ, P_SWI, P_SWJ, P_RF, P_WF,
        NEXT_KEY, DONE
    } state_t;

    state_t                        state;
    logic [KW-1:0]                 key;
    logic [KW-1:0]                 keyUpper;
    logic [RAM_LENGTH-1:0]         i;
    logic [RAM_LENGTH-1:0]         j;
    logic [RAM_WIDTH-1:0]          si;
    logic [RAM_WIDTH-1:0]          sj;
    logic [MESSAGE_LOG_LENGTH-1:0] k;
    logic [KIW-1:0]                keyIdx;
    logic                          failed;

    logic [KW:0]                   firstKey;
    logic [KW:0]                   nextKey;
    logic [RAM_WIDTH-1:0]          keyByte;
    logic [RAM_LENGTH-1:0]         jKsa;
    logic [RAM_LENGTH-1:0]         jPrga;
    logic [7:0]                    plainByte;
    logic                          printable;
    logic                          wfSuccess;

    // Range arithmetic is one bit wider than the key so the last key never wraps.
    assign firstKey = {1'b0, key_lower} + KW1'(CORE_ID);
    assign nextKey  = {1'b0, key} + KW1'(NUM_CORES);

    // Key byte (i mod KEY_LENGTH); byte 0 sits in the most significant position.
    always_comb begin
        keyByte = '0;
        for (int b = 0; b < KEY_LENGTH; b++) begin
            if (KIW'(b) == keyIdx) begin
                keyByte = key[(KEY_LENGTH-1-b)*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    assign jKsa      = j + RAM_LENGTH'(mem.sOut) + RAM_LENGTH'(keyByte);
    assign jPrga     = j + RAM_LENGTH'(mem.sOut);
    assign plainByte = mem.sOut[7:0] ^ mem.kOut;
    assign printable = ((plainByte >= 8'h61) && (plainByte <= 8'h7A)) || (plainByte == 8'h20);
    assign wfSuccess = (state == P_WF) && (k == LAST_BYTE) && printable && !failed;

    // Read data only arrives in the WF cycle, so the plaintext byte is formed
    // combinationally and gated by the registered write enable.
    assign mem.aIn = mem.aWren ? plainByte : 8'h00;
    assign outKey  = key;

    // Search sequencer: state, datapath registers and registered RAM controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            succeeded  <= 1'b0;
            terminated <= 1'b0;
            key        <= '0;
            keyUpper   <= '0;
            keys_tried <= '0;
            i          <= '0;
            j          <= '0;
            si         <= '0;
            sj         <= '0;
            k          <= '0;
            keyIdx     <= '0;
            failed     <= 1'b0;
            mem.sAddr  <= '0;
            mem.sIn    <= '0;
            mem.sWren  <= 1'b0;
            mem.kAddr  <= '0;
            mem.aAddr  <= '0;
            mem.aWren  <= 1'b0;
        end else if (halt && (state != IDLE) && (state != DONE) && !wfSuccess) begin
            if (state == NEXT_KEY) begin
                keys_tried <= keys_tried + 32'd1;
            end
            state      <= DONE;
            busy       <= 1'b0;
            succeeded  <= 1'b0;
            terminated <= 1'b1;
            mem.sWren  <= 1'b0;
            mem.aWren  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key        <= firstKey[KW-1:0];
                        keyUpper   <= key_upper;
                        succeeded  <= 1'b0;
                        keys_tried <= '0;
                        if (firstKey > {1'b0, key_upper}) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            terminated <= 1'b1;
                        end else begin
                            state      <= INIT;
                            busy       <= 1'b1;
                            terminated <= 1'b0;
                            failed     <= 1'b0;
                            i          <= '0;
                            mem.sAddr  <= '0;
                            mem.sIn    <= '0;
                            mem.sWren  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    if (i == IDX_MAX) begin
                        state     <= KSA_RI;
                        i         <= '0;
                        j         <= '0;
                        keyIdx    <= '0;
                        mem.sAddr <= '0;
                        mem.sWren <= 1'b0;
                    end else begin
                        i         <= i + 1'b1;
                        mem.sAddr <= i + 1'b1;
                        mem.sIn   <= RAM_WIDTH'(i + 1'b1);
                    end
                end
                KSA_RI: state <= KSA_WI;
                KSA_WI: begin
                    si        <= mem.sOut;
                    j         <= jKsa;
                    mem.sAddr <= jKsa;
                    state     <= KSA_RJ;
                end
                KSA_RJ: state <= KSA_WJ;
                KSA_WJ: begin
                    sj        <= mem.sOut;
                    mem.sAddr <= i;
                    mem.sIn   <= mem.sOut;
                    mem.sWren <= 1'b1;
                    state     <= KSA_SWI;
                end
                KSA_SWI: begin
                    mem.sAddr <= j;
                    mem.sIn   <= si;
                    state     <= KSA_SWJ;
                end
                KSA_SWJ: begin
                    mem.sWren <= 1'b0;
                    keyIdx    <= (keyIdx == KEY_IDX_MAX) ? '0 : keyIdx + 1'b1;
                    if (i == IDX_MAX) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= P_INC;
                    end else begin
                        i         <= i + 1'b1;
                        mem.sAddr <= i + 1'b1;
                        state     <= KSA_RI;
                    end
                end
                P_INC: begin
                    i         <= i + 1'b1;
                    mem.sAddr <= i + 1'b1;
                    state     <= P_RI;
                end
                P_RI: state <= P_WI;
                P_WI: begin
                    si        <= mem.sOut;
                    j         <= jPrga;
                    mem.sAddr <= jPrga;
                    state     <= P_RJ;
                end
                P_RJ: state <= P_WJ;
                P_WJ: begin
                    sj        <= mem.sOut;
                    mem.sAddr <= i;
                    mem.sIn   <= mem.sOut;
                    mem.sWren <= 1'b1;
                    state     <= P_SWI;
                end
                P_SWI: begin
                    mem.sAddr <= j;
                    mem.sIn   <= si;
                    state     <= P_SWJ;
                end
                P_SWJ: begin
                    mem.sWren <= 1'b0;
                    mem.sAddr <= RAM_LENGTH'(si + sj);
                    mem.kAddr <= k;
                    state     <= P_RF;
                end
                P_RF: begin
                    mem.aAddr <= k;
                    mem.aWren <= 1'b1;
                    state     <= P_WF;
                end
                P_WF: begin
                    mem.aWren <= 1'b0;
`ifdef ARCFOUR_EARLY_ABORT_EN
                    if (!printable) begin
                        state <= NEXT_KEY;
                    end else if (k == LAST_BYTE) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        succeeded  <= 1'b1;
                        terminated <= 1'b1;
                    end else begin
                        k     <= k + 1'b1;
                        state <= P_INC;
                    end
`else
                    if (k == LAST_BYTE) begin
                        if (failed || !printable) begin
                            state <= NEXT_KEY;
                        end else begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            succeeded  <= 1'b1;
                            terminated <= 1'b1;
                        end
                    end else begin
                        failed <= failed | ~printable;
                        k      <= k + 1'b1;
                        state  <= P_INC;
                    end
`endif
                end
                NEXT_KEY: begin
                    keys_tried <= keys_tried + 32'd1;
                    if (nextKey > {1'b0, keyUpper}) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        terminated <= 1'b1;
                    end else begin
                        key       <= nextKey[KW-1:0];
                        state     <= INIT;
                        failed    <= 1'b0;
                        i         <= '0;
                        mem.sAddr <= '0;
                        mem.sIn   <= '0;
                        mem.sWren <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arcfour_search_core.sv
// Self-checking bench for arcfour_search_core: two cores (stride 1 and stride 4 / id 2)
// with behavioural RAM/ROM models and an RC4 reference model of the key search.
module tb_arcfour_search_core;
    localparam int LIMIT = 30000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, halt0, start1, halt1;
    logic [23:0] lower0, upper0, lower1, upper1;
    logic        busy0, succ0, term0, busy1, succ1, term1;
    logic [23:0] outKey0, outKey1;
    logic [31:0] tried0, tried1;

    arcfour_search_core_if #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MESSAGE_LOG_LENGTH(5)) bus0 ();
    arcfour_search_core_if #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MESSAGE_LOG_LENGTH(5)) bus1 ();

    arcfour_search_core #(.NUM_CORES(1), .CORE_ID(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .halt(halt0),
        .key_lower(lower0), .key_upper(upper0),
        .busy(busy0), .succeeded(succ0), .terminated(term0),
        .outKey(outKey0), .keys_tried(tried0), .mem(bus0)
    );

    arcfour_search_core #(.NUM_CORES(4), .CORE_ID(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .halt(halt1),
        .key_lower(lower1), .key_upper(upper1),
        .busy(busy1), .succeeded(succ1), .terminated(term1),
        .outKey(outKey1), .keys_tried(tried1), .mem(bus1)
    );

    logic [7:0] rom [32];
    logic [7:0] plain [32];
    logic [7:0] sMem0 [256];
    logic [7:0] sMem1 [256];
    logic [7:0] aMem0 [32];
    logic [7:0] aMem1 [32];
    logic [7:0] ks [32];

    int checks = 0;
    int errors = 0;

    // Single-port S RAM, ciphertext ROM and plaintext RAM for each core (read latency 1).
    always @(posedge clk) begin
        if (bus0.sWren) sMem0[bus0.sAddr] <= bus0.sIn;
        bus0.sOut <= sMem0[bus0.sAddr];
        bus0.kOut <= rom[bus0.kAddr];
        if (bus0.aWren) aMem0[bus0.aAddr] <= bus0.aIn;
        if (bus1.sWren) sMem1[bus1.sAddr] <= bus1.sIn;
        bus1.sOut <= sMem1[bus1.sAddr];
        bus1.kOut <= rom[bus1.kAddr];
        if (bus1.aWren) aMem1[bus1.aAddr] <= bus1.aIn;
    end

    // RC4 keystream for a 3-byte key (byte 0 = most significant), first 32 bytes.
    function automatic void modelKeystream(input int key);
        int s [256];
        int jj, t, a;
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + ((key >> (8 * (2 - (x % 3)))) & 255)) % 256;
            t = s[x]; s[x] = s[jj]; s[jj] = t;
        end
        a = 0; jj = 0;
        for (int n = 0; n < 32; n++) begin
            a = (a + 1) % 256;
            jj = (jj + s[a]) % 256;
            t = s[a]; s[a] = s[jj]; s[jj] = t;
            ks[n] = 8'(s[(s[a] + s[jj]) % 256]);
        end
    endfunction

    function automatic bit isPrintable(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // Index of the first non-printable plaintext byte under key, 32 if none.
    function automatic int firstBad(input int key);
        modelKeystream(key);
        for (int n = 0; n < 32; n++) begin
            if (!isPrintable(rom[n] ^ ks[n])) return n;
        end
        return 32;
    endfunction

    // Expected outcome and edges-to-terminated of a whole search.
    task automatic modelSearch(input int lo, input int hi, input int stride, input int offset,
                               output bit eSucc, output int eKey, output int eTried, output int eCycles);
        int key, bad;
        key = lo + offset; eSucc = 0; eTried = 0; eCycles = 0; eKey = key;
        while (key <= hi) begin
            eKey = key;
            bad = firstBad(key);
            if (bad == 32) begin
                eSucc = 1; eCycles += 2080;
                break;
            end
            eTried++;
`ifdef ARCFOUR_EARLY_ABORT_EN
            eCycles += 256 + 1536 + 9 * (bad + 1) + 1;
`else
            eCycles += 2081;
`endif
            key += stride;
        end
    endtask

    // Random lowercase/space message, encrypted into the ROM under key.
    task automatic newMessage(input int key);
        modelKeystream(key);
        for (int n = 0; n < 32; n++) begin
            plain[n] = ($urandom_range(0, 26) == 26) ? 8'h20 : 8'h61 + 8'($urandom_range(0, 25));
            rom[n] = plain[n] ^ ks[n];
        end
    endtask

    // Start a search on core `which`; cycles = edges after the start edge until terminated, -1 on timeout.
    task automatic runSearch(input int which, input logic [23:0] lo, input logic [23:0] hi, output int cycles);
        @(posedge clk); #1;
        if (which == 0) begin lower0 = lo; upper0 = hi; start0 = 1'b1; end
        else begin lower1 = lo; upper1 = hi; start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        cycles = 0;
        while ((((which == 0) ? term0 : term1) == 1'b0) && (cycles < LIMIT)) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (((which == 0) ? term0 : term1) == 1'b0) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy0, succ0, term0, bus0.sWren, bus0.aWren} !== 5'b0) begin errors++; $display("FAIL reset_flags0 got %b want 00000", {busy0, succ0, term0, bus0.sWren, bus0.aWren}); end
        checks++; if ({outKey0, tried0} !== 56'h0) begin errors++; $display("FAIL reset_counts0 got %h/%h want 0/0", outKey0, tried0); end
        checks++; if ({bus0.sAddr, bus0.sIn, bus0.kAddr, bus0.aAddr, bus0.aIn} !== 34'h0) begin errors++; $display("FAIL reset_bus0 got %h want 0", {bus0.sAddr, bus0.sIn, bus0.kAddr, bus0.aAddr, bus0.aIn}); end
        checks++; if ({busy1, succ1, term1, outKey1, tried1} !== 59'h0) begin errors++; $display("FAIL reset_core1 got %h want 0", {busy1, succ1, term1, outKey1, tried1}); end
        reset = 1'b0;
    endtask

    task automatic checkAram0(input string name);
        int bad = 0;
        for (int n = 0; n < 32; n++) if (aMem0[n] !== plain[n]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_aram got %0d wrong bytes want 0", name, bad); end
    endtask

    task automatic test_search();
        bit eSucc; int eKey, eTried, eCycles, cyc;
        newMessage(24'h000018);
        modelSearch(24'h10, 24'h20, 1, 0, eSucc, eKey, eTried, eCycles);
        runSearch(0, 24'h000010, 24'h000020, cyc);
        checks++; if (cyc != eCycles) begin errors++; $display("FAIL search_cycles got %0d want %0d", cyc, eCycles); end
        checks++; if (succ0 !== 1'b1 || eSucc != 1) begin errors++; $display("FAIL search_succ got %b want 1 (model %0d)", succ0, eSucc); end
        checks++; if (outKey0 !== 24'h000018) begin errors++; $display("FAIL search_key got %h want 000018", outKey0); end
        checks++; if (tried0 !== 32'(eTried) || eTried != 8) begin errors++; $display("FAIL search_tried got %0d want 8 (model %0d)", tried0, eTried); end
        checkAram0("search");
    endtask

    task automatic test_exact_timing();
        int cyc, writes;
        runSearch(0, 24'h000018, 24'h000018, cyc);
        checks++; if (cyc != 2080) begin errors++; $display("FAIL exact_cycles got %0d want 2080", cyc); end
        checks++; if ({succ0, busy0} !== 2'b10) begin errors++; $display("FAIL exact_flags got succ=%b busy=%b want 1/0", succ0, busy0); end
        writes = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus0.aWren || bus0.sWren) writes++;
        end
        checks++; if (writes != 0 || term0 !== 1'b1) begin errors++; $display("FAIL exact_quiet got %0d writes term=%b want 0 writes term=1", writes, term0); end
        checkAram0("exact");
    endtask

    task automatic test_wrong_key();
        int w, cyc, expCyc;
        w = $urandom_range(24'h000100, 24'h00FFFF);
        while (firstBad(w) != 0) w++;
`ifdef ARCFOUR_EARLY_ABORT_EN
        expCyc = 1802;
`else
        expCyc = 2081;
`endif
        runSearch(0, 24'(w), 24'(w), cyc);
        checks++; if (cyc != expCyc) begin errors++; $display("FAIL wrong_cycles got %0d want %0d", cyc, expCyc); end
        checks++; if ({succ0, tried0} !== {1'b0, 32'd1}) begin errors++; $display("FAIL wrong_result got succ=%b tried=%0d want 0/1", succ0, tried0); end
        checks++; if (outKey0 !== 24'(w)) begin errors++; $display("FAIL wrong_key got %h want %h", outKey0, 24'(w)); end
    endtask

    task automatic test_stride();
        bit eSucc; int eKey, eTried, eCycles, cyc;
        logic [7:0] exp0;
        modelSearch(0, 9, 4, 2, eSucc, eKey, eTried, eCycles);
        runSearch(1, 24'd0, 24'd9, cyc);
        modelKeystream(6);
        exp0 = rom[0] ^ ks[0];
        checks++; if (cyc != eCycles) begin errors++; $display("FAIL stride_cycles got %0d want %0d", cyc, eCycles); end
        checks++; if (tried1 !== 32'(eTried) || eTried != 2) begin errors++; $display("FAIL stride_tried got %0d want 2 (model %0d)", tried1, eTried); end
        checks++; if ({succ1, term1} !== 2'b01 || eSucc != 0) begin errors++; $display("FAIL stride_flags got succ=%b term=%b want 0/1", succ1, term1); end
        checks++; if (outKey1 !== 24'd6 || eKey != 6) begin errors++; $display("FAIL stride_key got %h want 6", outKey1); end
        checks++; if (aMem1[0] !== exp0) begin errors++; $display("FAIL stride_aram got %h want %h", aMem1[0], exp0); end
    endtask

    task automatic test_halt();
        int d, writes;
        @(posedge clk); #1;
        lower0 = 24'h000010; upper0 = 24'h000020; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        d = $urandom_range(266, 1756);
        repeat (d) @(posedge clk);
        #1;
        checks++; if ({busy0, term0} !== 2'b10) begin errors++; $display("FAIL halt_busy got busy=%b term=%b want 1/0", busy0, term0); end
        halt0 = 1'b1;
        @(posedge clk); #1;
        halt0 = 1'b0;
        checks++; if ({term0, succ0, busy0} !== 3'b100) begin errors++; $display("FAIL halt_flags got %b want 100", {term0, succ0, busy0}); end
        writes = 0;
        repeat (40) begin
            if (bus0.sWren || bus0.aWren) writes++;
            @(posedge clk); #1;
        end
        checks++; if (writes != 0) begin errors++; $display("FAIL halt_quiet got %0d write cycles want 0", writes); end
    endtask

    task automatic test_empty_range();
        int cyc;
        runSearch(0, 24'd10, 24'd9, cyc);
        checks++; if (cyc != 0) begin errors++; $display("FAIL empty0_cycles got %0d want 0", cyc); end
        checks++; if ({succ0, busy0, bus0.sWren, tried0} !== 35'h0) begin errors++; $display("FAIL empty0_state got succ=%b busy=%b sWren=%b tried=%0d want 0", succ0, busy0, bus0.sWren, tried0); end
        runSearch(1, 24'd8, 24'd9, cyc);
        checks++; if (cyc != 0 || succ1 !== 1'b0) begin errors++; $display("FAIL empty1 got cycles=%0d succ=%b want 0/0", cyc, succ1); end
    endtask

    task automatic test_reset_mid_prga();
        @(posedge clk); #1;
        lower0 = 24'h000018; upper0 = 24'h000018; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (256 + 1536 + $urandom_range(1, 280)) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy0, succ0, term0, bus0.sWren, bus0.aWren} !== 5'b0) begin errors++; $display("FAIL midreset_flags got %b want 00000", {busy0, succ0, term0, bus0.sWren, bus0.aWren}); end
        checks++; if ({outKey0, tried0, bus0.sAddr, bus0.sIn, bus0.kAddr, bus0.aAddr, bus0.aIn} !== 90'h0) begin errors++; $display("FAIL midreset_values got key=%h tried=%0d sAddr=%h aAddr=%h want 0", outKey0, tried0, bus0.sAddr, bus0.aAddr); end
    endtask

    task automatic test_random_search();
        bit eSucc; int eKey, eTried, eCycles, cyc, kk, lo, hi;
        kk = $urandom_range(3, 24'hFFFFF0);
        lo = kk - $urandom_range(0, 2);
        hi = kk + $urandom_range(0, 2);
        newMessage(kk);
        modelSearch(lo, hi, 1, 0, eSucc, eKey, eTried, eCycles);
        runSearch(0, 24'(lo), 24'(hi), cyc);
        checks++; if (cyc != eCycles) begin errors++; $display("FAIL rand_cycles got %0d want %0d", cyc, eCycles); end
        checks++; if (succ0 !== eSucc || outKey0 !== 24'(eKey)) begin errors++; $display("FAIL rand_result got succ=%b key=%h want %0d/%h", succ0, outKey0, eSucc, 24'(eKey)); end
        checks++; if (tried0 !== 32'(eTried)) begin errors++; $display("FAIL rand_tried got %0d want %0d", tried0, eTried); end
        if (eKey == kk) checkAram0("rand");
    endtask

    initial begin
        reset = 1'b1;
        start0 = 1'b0; halt0 = 1'b0; start1 = 1'b0; halt1 = 1'b0;
        lower0 = '0; upper0 = '0; lower1 = '0; upper1 = '0;
        for (int n = 0; n < 32; n++) rom[n] = 8'h00;
        test_reset();
        test_search();
        test_exact_timing();
        test_wrong_key();
        test_stride();
        test_halt();
        test_empty_range();
        test_reset_mid_prga();
        test_random_search();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arcfour_search_core.md
# arcfour_search_core

Parametrised RC4 brute-force key-search engine, successor to the single-range `arcfour` block. It initialises and schedules S in an external single-port RAM, then decrypts a ciphertext ROM into an output RAM. It iterates over a runtime key range with a per-core stride so that NUM_CORES instances partition one keyspace, and stops on a printable plaintext, on range exhaustion, or when another core signals `halt`. It sits between the top-level key/switch logic and the S, message and result RAMs.

## Interface
- RAM_WIDTH, 8: S data width; must equal RAM_LENGTH, elaboration error otherwise
- RAM_LENGTH, 8: S address bits; S depth = 2^RAM_LENGTH
- KEY_LENGTH, 3: key bytes; key width KW = KEY_LENGTH*RAM_WIDTH
- MESSAGE_LENGTH, 32: ciphertext bytes
- MESSAGE_LOG_LENGTH, 5: message address bits
- NUM_CORES, 1: key stride
- CORE_ID, 0: offset of first key from key_lower, 0..NUM_CORES-1

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins search
- halt  in  1  abort request (e.g. OR of other cores' succeeded)
- key_lower, key_upper  in  KW  inclusive search range, sampled with start
- busy  out  1  high from the cycle after start until DONE
- succeeded  out  1  valid key found
- terminated  out  1  search finished (any cause)
- outKey  out  KW  current candidate; holds the winning key on success
- keys_tried  out  32  count of keys rejected
- sAddr out RAM_LENGTH, sIn out RAM_WIDTH, sWren out 1, sOut in RAM_WIDTH  S RAM
- kAddr out MESSAGE_LOG_LENGTH, kOut in 8  ciphertext ROM
- aAddr out MESSAGE_LOG_LENGTH, aIn out 8, aWren out 1  plaintext RAM

## Operation
- Reset values: busy, succeeded, terminated, sWren, aWren = 0. outKey, keys_tried, all addresses and data = 0. State = IDLE.
- Reset mid-operation: IDLE on the next cycle with reset values; RAM contents undefined.
- IDLE/DONE: start loads key = key_lower+CORE_ID and clears flags and keys_tried. start is ignored in any other state.
- Empty range (key_lower+CORE_ID > key_upper, compared at KW+1 bits): DONE next cycle, terminated=1, no RAM writes.
- INIT: one write per cycle, S[i]=i, i=0..2^RAM_LENGTH-1.
- KSA, 6 states per i:
  - KSA_RI: sAddr=i
  - KSA_WI: si=sOut, j+=si+key byte (i mod KEY_LENGTH); byte 0 is the MSB byte
  - KSA_RJ: sAddr=j
  - KSA_WJ: sj=sOut
  - KSA_SWI: write S[i]=sj
  - KSA_SWJ: write S[j]=si
- PRGA: i and j cleared at entry; 9 states per byte k:
  - INC: i+=1
  - RI, WI: read si; j+=si
  - RJ, WJ: read sj
  - SWI, SWJ: swap
  - RF: sAddr=si+sj, kAddr=k
  - WF: aIn=sOut^kOut, aAddr=k, aWren=1
- All index arithmetic is mod 2^RAM_LENGTH.
- Printable byte: 8'h61..8'h7A or 8'h20.
- NEXT_KEY (1 cycle): keys_tried+=1.
  - If key+NUM_CORES > key_upper (KW+1 bits, no wrap) or halt: DONE, terminated=1.
  - Otherwise key+=NUM_CORES and go to INIT.
- Success: after WF of byte MESSAGE_LENGTH-1 with no failure, go to DONE with succeeded=terminated=1 and outKey frozen.
- halt in any non-IDLE/non-DONE state: DONE next cycle, succeeded=0, no further writes. If halt and success coincide in WF, success wins.

## Timing
- RAM read latency is 1: address in cycle N, sOut/kOut valid in N+1. Writes commit at the edge; a read issued the next cycle sees the new data.
- Per key: 2^RAM_LENGTH INIT + 6·2^RAM_LENGTH KSA + 9 per decrypted byte.
- Defaults, correct key first: terminated rises 256+1536+288 = 2080 edges after the start-sampling edge.
- terminated and succeeded hold until start or reset. busy falls the same edge that terminated rises.

## Configuration
- ARCFOUR_EARLY_ABORT_EN defined: the first non-printable byte in WF goes directly to NEXT_KEY. A key failing at byte 0 costs 256+1536+9+1 = 1802 cycles.
- Not defined: failure is latched and decryption of all MESSAGE_LENGTH bytes continues. The latched flag is checked after the last WF. Every wrong key costs 2081 cycles.
- The plaintext RAM reflects the last key tried in both builds.

## Test plan
- ROM holds a 32-byte lowercase string encrypted under 24'h000018; range 24'h000010–24'h000020, NUM_CORES=1 -> succeeded=1, outKey=24'h000018, keys_tried=8, A RAM equals the plaintext.
- key_lower=key_upper=correct key -> terminated exactly 2080 cycles after start; no aWren after that.
- Wrong key whose byte 0 decrypts non-printable -> NEXT_KEY reached after 1801 cycles with the macro, 2080 without.
- NUM_CORES=4, CORE_ID=2, range 0–9, no valid key -> keys 2 and 6 tried, keys_tried=2, succeeded=0, terminated=1.
- halt pulsed during KSA -> terminated=1 the next cycle, succeeded=0, sWren=aWren=0 thereafter. Empty range (key_lower=10, key_upper=9) -> terminated one cycle after start.
- reset asserted mid-PRGA -> next cycle all outputs at reset values. A new start then runs a full search correctly.
